// File: rtl/aes_cnt_poller.sv
// Avalon-MM master for the AES counter register block: writes MSG_WORD_CNT on
// request and reads all three word counters back as one coherent snapshot.
module aes_cnt_poller #(
  parameter logic [63:0] BASE_ADDR         = 64'h1000,
  parameter int unsigned ADDRESS_SIZE      = 32,
  parameter int unsigned REG_SIZE          = 32,
  parameter int unsigned WORD_COUNTER_SIZE = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         wr_req,
  input  logic [WORD_COUNTER_SIZE-1:0] wr_data,
  output logic                         busy,
  output logic [ADDRESS_SIZE-1:0]      avm_address,
  output logic                         avm_read,
  output logic                         avm_write,
  output logic [REG_SIZE-1:0]          avm_writedata,
  input  logic                         avm_waitrequest,
  input  logic [REG_SIZE-1:0]          avm_readdata,
  input  logic                         avm_readdatavalid,
  output logic [WORD_COUNTER_SIZE-1:0] msg_cnt,
  output logic [WORD_COUNTER_SIZE-1:0] adder_cnt,
  output logic [WORD_COUNTER_SIZE-1:0] remover_cnt,
  output logic                         snap_valid,
  output logic                         mismatch,
  output logic                         range_err,
  output logic                         wr_done,
  output logic                         err_timeout
);

  localparam int unsigned CW = WORD_COUNTER_SIZE;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [CW-1:0]           sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
  logic                    tmo;

  logic                    busy_d, read_d, write_d, snap_d, mism_d, rerr_d, wr_done_d, to_d;
  logic [ADDRESS_SIZE-1:0] addr_d;
  logic [REG_SIZE-1:0]     wdata_d;
  logic [CW-1:0]           msg_d, adder_d, rem_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      pend_q        <= 1'b0;
      tcnt_q        <= '0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      busy          <= 1'b0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      msg_cnt       <= '0;
      adder_cnt     <= '0;
      remover_cnt   <= '0;
      snap_valid    <= 1'b0;
      mismatch      <= 1'b0;
      range_err     <= 1'b0;
      wr_done       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      tcnt_q        <= tcnt_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      busy          <= busy_d;
      avm_address   <= addr_d;
      avm_read      <= read_d;
      avm_write     <= write_d;
      avm_writedata <= wdata_d;
      msg_cnt       <= msg_d;
      adder_cnt     <= adder_d;
      remover_cnt   <= rem_d;
      snap_valid    <= snap_d;
      mismatch      <= mism_d;
      range_err     <= rerr_d;
      wr_done       <= wr_done_d;
      err_timeout   <= to_d;
    end
  end

  assign tmo = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    tcnt_d    = tcnt_q + TW'(1);
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    wdata_d   = avm_writedata;
    msg_d     = msg_cnt;
    adder_d   = adder_cnt;
    rem_d     = remover_cnt;
    mism_d    = mismatch;
    rerr_d    = range_err;
    snap_d    = 1'b0;
    wr_done_d = 1'b0;
    to_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (wr_req) begin
          state_d = WR;
          pend_d  = start;
          wdata_d = REG_SIZE'(wr_data);
        end else if (start || pend_q) begin
          state_d = RD_REQ;
          idx_d   = 2'd0;
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          wr_done_d = 1'b1;
          wdata_d   = '0;
          tcnt_d    = '0;
          idx_d     = 2'd0;
          state_d   = pend_q ? RD_REQ : IDLE;
        end else if (tmo) begin
          to_d    = 1'b1;
          pend_d  = 1'b0;
          wdata_d = '0;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          state_d = RD_WAIT;
        end else if (tmo) begin
          to_d    = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          case (idx_q)
            2'd0:    sh0_d = avm_readdata[CW-1:0];
            2'd1:    sh1_d = avm_readdata[CW-1:0];
            default: sh2_d = avm_readdata[CW-1:0];
          endcase
          if (avm_readdata[REG_SIZE-1:CW] != '0) rerr_d = 1'b1;
          tcnt_d = '0;
          if (idx_q == 2'd2) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD_REQ;
          end
        end else if (tmo) begin
          to_d    = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DONE: begin
        msg_d   = sh0_q;
        adder_d = sh1_q;
        rem_d   = sh2_q;
        mism_d  = (sh1_q != sh0_q) || (sh2_q != sh0_q);
        snap_d  = 1'b1;
        pend_d  = 1'b0;
        tcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus controls follow the state being entered so they are glitch-free flops
    busy_d  = (state_d != IDLE);
    read_d  = (state_d == RD_REQ);
    write_d = (state_d == WR);
    addr_d  = '0;
    if (state_d == WR)
      addr_d = ADDRESS_SIZE'(BASE_ADDR);
    else if (state_d == RD_REQ)
      addr_d = ADDRESS_SIZE'(BASE_ADDR) + ADDRESS_SIZE'({idx_d, 2'b00});
  end

endmodule

// File: tb/tb_aes_cnt_poller.sv
// Directed bench: Avalon slave model plus a cycle-level expectation model of
// snapshot, write-done, timeout and range-error events.
module tb_aes_cnt_poller;

  localparam int unsigned TMO = 255;
  localparam logic [31:0] BASE = 32'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        busy;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic [7:0]  msg_cnt, adder_cnt, remover_cnt;
  logic        snap_valid, mismatch, range_err, wr_done, err_timeout;

  aes_cnt_poller #(
    .BASE_ADDR(64'h1000), .ADDRESS_SIZE(32), .REG_SIZE(32),
    .WORD_COUNTER_SIZE(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .wr_data(wr_data),
    .busy(busy), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .msg_cnt(msg_cnt),
    .adder_cnt(adder_cnt), .remover_cnt(remover_cnt), .snap_valid(snap_valid),
    .mismatch(mismatch), .range_err(range_err), .wr_done(wr_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Slave configuration and expectation model
  logic [31:0] mem [3];
  int          drop_off = 3;
  int          rd_wait_cfg = 0;
  int          wr_wait_cfg = 0;
  logic [31:0] exp_wd = 32'h0;
  logic        stray_req = 1'b0;
  logic [7:0]  m_sh [3];
  logic [7:0]  exp_msg = 0, exp_adder = 0, exp_rem = 0;
  logic        exp_mism = 0, exp_rerr = 0;
  int          snap_cd = 0, rng_cd = 0, wr_cd = 0, to_cd = 0;
  logic        in_tx = 0, acc_pending = 0;
  int          wait_left = 0, acc_off = 0, write_cycles = 0;
  logic [31:0] hold_addr = 0;
  logic [1:0]  hold_type = 0;
  logic [31:0] addr_q [$];
  int          t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_msg = 0; exp_adder = 0; exp_rem = 0; exp_mism = 0; exp_rerr = 0;
    snap_cd = 0; rng_cd = 0; wr_cd = 0; to_cd = 0;
    in_tx = 0; acc_pending = 0; wait_left = 0;
    for (int i = 0; i < 3; i++) m_sh[i] = 8'h0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
  endtask

  // One negedge: advance expectations, compare, then drive the slave
  task automatic step();
    logic ex_snap, ex_wd, ex_to;
    int   off;
    if (rst) begin
      model_reset();
      return;
    end
    ex_snap = 0; ex_wd = 0; ex_to = 0;
    if (snap_cd > 0) begin
      snap_cd--;
      if (snap_cd == 0) begin
        ex_snap   = 1;
        exp_msg   = m_sh[0];
        exp_adder = m_sh[1];
        exp_rem   = m_sh[2];
        exp_mism  = (m_sh[1] != m_sh[0]) || (m_sh[2] != m_sh[0]);
      end
    end
    if (rng_cd > 0) begin
      rng_cd--;
      if (rng_cd == 0) exp_rerr = 1;
    end
    if (wr_cd > 0) begin
      wr_cd--;
      ex_wd = (wr_cd == 0);
    end
    if (to_cd > 0) begin
      to_cd--;
      ex_to = (to_cd == 0);
    end
    chk("snap_valid", 32'(snap_valid), 32'(ex_snap));
    chk("msg_cnt", 32'(msg_cnt), 32'(exp_msg));
    chk("adder_cnt", 32'(adder_cnt), 32'(exp_adder));
    chk("remover_cnt", 32'(remover_cnt), 32'(exp_rem));
    chk("mismatch", 32'(mismatch), 32'(exp_mism));
    chk("range_err", 32'(range_err), 32'(exp_rerr));
    chk("wr_done", 32'(wr_done), 32'(ex_wd));
    chk("err_timeout", 32'(err_timeout), 32'(ex_to));
    chk("rd_wr_exclusive", 32'(avm_read & avm_write), 32'h0);
    if (ex_snap || ex_to) chk("busy_after_end", 32'(busy), 32'h0);
    if (avm_read || avm_write) chk("busy_active", 32'(busy), 32'h1);

    avm_readdatavalid = 0;
    avm_readdata      = 0;
    if (stray_req) begin
      stray_req         = 0;
      avm_readdatavalid = 1;
      avm_readdata      = 32'h1FF;
    end
    if (acc_pending) begin
      acc_pending = 0;
      if (acc_off != drop_off) begin
        avm_readdatavalid = 1;
        avm_readdata      = mem[acc_off];
        m_sh[acc_off]     = mem[acc_off][7:0];
        if (mem[acc_off][31:8] != 0) rng_cd = 1;
        if (acc_off == 2) snap_cd = 2;
      end
    end
    if (avm_read || avm_write) begin
      off = int'((avm_address - BASE) >> 2);
      if (!in_tx) begin
        in_tx     = 1;
        hold_addr = avm_address;
        hold_type = {avm_read, avm_write};
        wait_left = avm_read ? rd_wait_cfg : wr_wait_cfg;
        if (avm_read && off == drop_off) to_cd = TMO;
      end else begin
        chk("addr_hold", avm_address, hold_addr);
        chk("type_hold", 32'({avm_read, avm_write}), 32'(hold_type));
      end
      if (avm_write) begin
        write_cycles++;
        chk("writedata", avm_writedata, exp_wd);
      end
      if (wait_left > 0) begin
        avm_waitrequest = 1;
        wait_left--;
      end else begin
        avm_waitrequest = 0;
        in_tx = 0;
        if (avm_read) begin
          acc_pending = 1;
          acc_off     = off;
          addr_q.push_back(avm_address);
        end else begin
          wr_cd = 1;
        end
      end
    end else begin
      avm_waitrequest = 0;
      in_tx = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_snap(output logic found, output int lat);
    found = 0;
    lat = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (snap_valid) found = 1;
      else @(negedge clk);
    end
    lat = cyc - t0;
  endtask

  task automatic set_mem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    mem[0] = a; mem[1] = b; mem[2] = c;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({busy, avm_read, avm_write, snap_valid, mismatch,
                              range_err, wr_done, err_timeout}), 32'h0);
    chk({tag, "_counts"}, 32'({msg_cnt, adder_cnt, remover_cnt}), 32'h0);
    chk({tag, "_address"}, avm_address, 32'h0);
    chk({tag, "_writedata"}, avm_writedata, 32'h0);
  endtask

  task automatic sweep(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    logic found;
    int   lat;
    set_mem(a, b, c);
    addr_q.delete();
    pulse_start();
    wait_snap(found, lat);
    chk({tag, "_snap_seen"}, 32'(found), 32'h1);
    chk({tag, "_latency"}, 32'(lat), 32'd7);
    chk({tag, "_nreads"}, 32'(addr_q.size()), 32'd3);
    if (addr_q.size() == 3) begin
      chk({tag, "_addr0"}, addr_q[0], 32'h1000);
      chk({tag, "_addr1"}, addr_q[1], 32'h1004);
      chk({tag, "_addr2"}, addr_q[2], 32'h1008);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic found;
    int   lat;
    set_mem(0, 0, 0);
    for (int i = 0; i < 3; i++) m_sh[i] = 8'h0;
    fork
      forever begin
        @(negedge clk);
        step();
      end
      begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 0;

    // Consistent sweep
    sweep("sweep555", 32'd5, 32'd5, 32'd5);
    chk("s555_msg", 32'(msg_cnt), 32'd5);
    chk("s555_adder", 32'(adder_cnt), 32'd5);
    chk("s555_rem", 32'(remover_cnt), 32'd5);
    chk("s555_mismatch", 32'(mismatch), 32'd0);

    // Remover disagrees
    sweep("sweep998", 32'd9, 32'd9, 32'd8);
    chk("s998_rem", 32'(remover_cnt), 32'd8);
    chk("s998_mismatch", 32'(mismatch), 32'd1);

    // Write with stalls and start in the same cycle
    set_mem(32'h11, 32'h11, 32'h11);
    rd_wait_cfg = 1; wr_wait_cfg = 3; exp_wd = 32'h2A; write_cycles = 0;
    addr_q.delete();
    @(negedge clk);
    wr_req = 1; wr_data = 8'h2A; start = 1;
    @(negedge clk);
    wr_req = 0; wr_data = 8'h00; start = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wr_done) found = 1;
      else @(negedge clk);
    end
    chk("wr_done_seen", 32'(found), 32'h1);
    chk("write_cycles", 32'(write_cycles), 32'd4);
    wait_snap(found, lat);
    chk("wr_sweep_snap", 32'(found), 32'h1);
    chk("wr_sweep_msg", 32'(msg_cnt), 32'h11);
    chk("wr_sweep_nreads", 32'(addr_q.size()), 32'd3);
    repeat (2) @(negedge clk);
    rd_wait_cfg = 0; wr_wait_cfg = 0;

    // Out-of-range adder word, then sticky through a clean sweep
    sweep("range", 32'd3, 32'h103, 32'd3);
    chk("range_adder", 32'(adder_cnt), 32'd3);
    chk("range_err_set", 32'(range_err), 32'd1);
    chk("range_mismatch", 32'(mismatch), 32'd0);
    sweep("clean", 32'd4, 32'd4, 32'd4);
    chk("range_err_sticky", 32'(range_err), 32'd1);
    chk("clean_msg", 32'(msg_cnt), 32'd4);

    // Adder read never answered
    set_mem(32'd7, 32'd7, 32'd7);
    drop_off = 1;
    pulse_start();
    found = 0;
    for (int i = 0; i < TMO + 50 && !found; i++) begin
      if (err_timeout) found = 1;
      else @(negedge clk);
    end
    chk("timeout_seen", 32'(found), 32'h1);
    chk("timeout_latency", 32'(cyc - t0), 32'd257);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_msg_kept", 32'(msg_cnt), 32'd4);
    repeat (10) @(negedge clk);
    drop_off = 3;

    // Asynchronous reset while waiting for read data
    drop_off = 1;
    pulse_start();
    repeat (6) @(negedge clk);
    #2 rst = 1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    #2 rst = 0;
    drop_off = 3;
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("stray_range_err", 32'(range_err), 32'h0);
    chk("stray_busy", 32'(busy), 32'h0);
    sweep("post_reset", 32'd6, 32'd6, 32'd6);
    chk("post_reset_msg", 32'(msg_cnt), 32'd6);
    chk("post_reset_range", 32'(range_err), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_cnt_poller.md
Name: aes_cnt_poller

Overview:
Avalon-MM master that talks to the AES peripheral's counter register block, which is an Avalon-MM slave. On request it writes a new message word count to MSG_WORD_CNT. On start it reads MSG_WORD_CNT, ADDER_WORD_CNT and REMOVER_WORD_CNT in sequence and presents them as one coherent snapshot with a consistency check. It sits between the test/control logic and the peripheral's slave port.

Parameters:
BASE_ADDR, 'h1000, peripheral base address; register addresses are BASE_ADDR+'h0, +'h4, +'h8.
ADDRESS_SIZE, 32, Avalon address width.
REG_SIZE, 32, Avalon data width.
WORD_COUNTER_SIZE, 8, counter width captured from readdata.
TIMEOUT_CYCLES, 255, maximum cycles allowed per transaction before abort (at least 1).

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; requests a three-register read sweep
wr_req  in  1  one-cycle pulse; requests a write of wr_data to MSG_WORD_CNT
wr_data  in  WORD_COUNTER_SIZE  value for MSG_WORD_CNT, zero-extended to REG_SIZE
busy  out  1  high whenever the FSM is not in IDLE
avm_address  out  ADDRESS_SIZE  Avalon address
avm_read  out  1  Avalon read request
avm_write  out  1  Avalon write request
avm_writedata  out  REG_SIZE  Avalon write data
avm_waitrequest  in  1  slave stall
avm_readdata  in  REG_SIZE  read data
avm_readdatavalid  in  1  read data qualifier
msg_cnt, adder_cnt, remover_cnt  out  WORD_COUNTER_SIZE each  last snapshot
snap_valid  out  1  one-cycle pulse: new snapshot on the count outputs
mismatch  out  1  registered with the snapshot: (adder_cnt!=msg_cnt) or (remover_cnt!=msg_cnt)
range_err  out  1  sticky: some captured readdata had nonzero bits above WORD_COUNTER_SIZE
wr_done  out  1  one-cycle pulse when the write is accepted
err_timeout  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset: all outputs are 0 immediately. The FSM goes to IDLE, any pending start is cleared and an in-flight transaction is abandoned.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, DONE. A 2-bit index selects the register (0/1/2 -> offset 0/4/8).
- IDLE:
  - If wr_req, go to WR. If start is also high in the same cycle, latch it as pending.
  - Else if start or pending, go to RD_REQ with index 0.
  - start or wr_req arriving while busy is ignored, except for the latch case above.
- WR:
  - avm_write=1, avm_address=BASE_ADDR, avm_writedata={0,wr_data}. wr_data is sampled at acceptance of wr_req and held.
  - All signals are held stable while avm_waitrequest=1.
  - On the cycle waitrequest=0: the write completes, wr_done pulses next cycle, and the FSM goes to RD_REQ if pending, else IDLE.
- RD_REQ:
  - avm_read=1, avm_address=BASE_ADDR+4*index, both held while waitrequest=1.
  - On waitrequest=0, go to RD_WAIT.
  - Only one read is outstanding at a time.
- RD_WAIT:
  - avm_read=0.
  - On avm_readdatavalid, capture readdata[WORD_COUNTER_SIZE-1:0] into a shadow register for the current index, and set range_err if the upper bits are nonzero.
  - If index=2, go to DONE; else increment index and go to RD_REQ.
  - readdatavalid in any other state is ignored.
- DONE:
  - Copy the three shadows to the outputs together and compute mismatch.
  - snap_valid is high for exactly one cycle, with the outputs already valid. Clear pending and go to IDLE.
- Latency: with a zero-wait slave returning readdatavalid the cycle after acceptance, snap_valid is asserted 7 cycles after the cycle start is sampled.
- Timeout:
  - A per-transaction counter resets on entry to WR or RD_REQ and counts in WR, RD_REQ and RD_WAIT.
  - On reaching TIMEOUT_CYCLES without completion: deassert read/write, pulse err_timeout, clear pending, go to IDLE.
  - Snapshot outputs and mismatch are unchanged after a timeout.
- Addresses: computed in ADDRESS_SIZE-bit arithmetic, wrap modulo 2^ADDRESS_SIZE. avm_read and avm_write are never high together.
- range_err is cleared only by reset.

Test Plan:
- Zero-wait slave returning 5, 5, 5; pulse start -> avm_address 'h1000, 'h1004, 'h1008 in order; snap_valid 7 cycles after start; counts 5/5/5; mismatch=0.
- Slave returns 9, 9, 8 -> remover_cnt=8, mismatch=1 with snap_valid.
- wr_req with wr_data='h2A and start in the same cycle; slave waitrequest=1 for 3 cycles -> avm_write held 4 cycles with avm_writedata='h0000002A; wr_done pulse; then the read sweep runs.
- Slave never asserts readdatavalid for the 'h1004 read -> err_timeout pulses after TIMEOUT_CYCLES; busy drops; counts keep their previous values; no snap_valid.
- ADDER_WORD_CNT read returns 'h00000103 -> adder_cnt=3, range_err=1 and stays 1 through a later clean sweep.
- rst asserted mid-RD_WAIT -> all outputs 0 asynchronously; a stray readdatavalid after release is ignored; the next start gives a normal sweep.
